// File: rtl/video_csc_out_if.sv
// Video bus between the core and the analogue output colour-space converter.
// Master drives raw RGB plus sync; slave returns converted video and delayed sync.
interface video_csc_out_if #(parameter int DW = 8);
  logic [1:0]      mode_req;
  logic            hsync;
  logic            vsync;
  logic            csync;
  logic            de;
  logic [3*DW-1:0] din;
  logic [3*DW-1:0] dout;
  logic            hsync_o;
  logic            vsync_o;
  logic            csync_o;
  logic            de_o;
  logic [1:0]      mode_active;

  modport master (
    output mode_req, hsync, vsync, csync, de, din,
    input  dout, hsync_o, vsync_o, csync_o, de_o, mode_active
  );

  modport slave (
    input  mode_req, hsync, vsync, csync, de, din,
    output dout, hsync_o, vsync_o, csync_o, de_o, mode_active
  );
endinterface

// File: rtl/video_csc_out.sv
// RGB -> RGB / YPbPr (601, 709) / YCbCr (601 limited) converter with matched sync delay.
// Mode changes take effect only on a vsync rising edge so frames are never mixed.
module video_csc_lane #(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DW-1:0]     r,
  input  logic [DW-1:0]     g,
  input  logic [DW-1:0]     b,
  input  logic signed [9:0] kr,
  input  logic signed [9:0] kg,
  input  logic signed [9:0] kb,
  input  logic [DW-1:0]     off,
  input  logic              blank,
  output logic [DW-1:0]     q
);
  localparam int SW = DW + 11;

  logic signed [SW-1:0] sum, sum_nx;
  logic signed [SW:0]   acc;
  logic [DW+3:0]        res;
  logic [DW-1:0]        clamped;

  always_comb begin
    sum_nx = SW'($signed({1'b0, r})) * SW'(kr)
           + SW'($signed({1'b0, g})) * SW'(kg)
           + SW'($signed({1'b0, b})) * SW'(kb);
    acc = (SW+1)'(sum) + $signed((SW+1)'({off, 8'd0})) + (SW+1)'(128);
    res = acc[SW:8];
    // res[DW+3] is the sign; any of res[DW+2:DW] set means above full scale
    if (res[DW+3])           clamped = '0;
    else if (|res[DW+2:DW])  clamped = '1;
    else                     clamped = res[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
      q   <= '0;
    end else begin
      sum <= sum_nx;
      q   <= blank ? off : clamped;
    end
  end
endmodule

module video_csc_out #(
  parameter int DW          = 8,
  parameter int EXTRA_DELAY = 0,
  parameter int BLANK       = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  video_csc_out_if.slave  vid
);
  localparam int NUM_LANES = 3;
  localparam int OW        = 3*DW + 4;
  localparam logic [DW-1:0] Y_LIM = DW'(16  << (DW-8));
  localparam logic [DW-1:0] C_MID = DW'(128 << (DW-8));

  function automatic logic [9:0] k10(input int v);
    return 10'(v);
  endfunction

  // lane 2 = R / Pr / Cr, lane 1 = G / Y, lane 0 = B / Pb / Cb; packed {kr,kg,kb}
  function automatic logic [29:0] coefs(input logic [1:0] m, input int ln);
    logic [29:0] k;
    k = '0;
    case ({m, 2'(ln)})
      4'b00_10: k = {k10(256),  k10(0),    k10(0)};
      4'b00_01: k = {k10(0),    k10(256),  k10(0)};
      4'b00_00: k = {k10(0),    k10(0),    k10(256)};
      4'b01_10: k = {k10(128),  k10(-107), k10(-21)};
      4'b01_01: k = {k10(77),   k10(150),  k10(29)};
      4'b01_00: k = {k10(-43),  k10(-85),  k10(128)};
      4'b10_10: k = {k10(112),  k10(-94),  k10(-18)};
      4'b10_01: k = {k10(66),   k10(129),  k10(25)};
      4'b10_00: k = {k10(-38),  k10(-74),  k10(112)};
      4'b11_10: k = {k10(128),  k10(-116), k10(-12)};
      4'b11_01: k = {k10(54),   k10(183),  k10(19)};
      4'b11_00: k = {k10(-29),  k10(-99),  k10(128)};
      default:  k = '0;
    endcase
    return k;
  endfunction

  logic [3*DW-1:0] rgb_s1, dout_s3;
  logic [3:0]      sync_s1, sync_s2, sync_s3;  // {hsync, vsync, csync, de}
  logic [1:0]      mode_active, mode_s2, mode_nx;
  logic            vs_rise, blank_s2;
  logic [DW-1:0]   y_off, c_off;
  logic [OW-1:0]   out_s3, out_w;

  assign vs_rise = vid.vsync & ~sync_s1[2];
  assign mode_nx = vs_rise ? vid.mode_req : mode_active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_s1      <= '0;
      sync_s1     <= '0;
      sync_s2     <= '0;
      sync_s3     <= '0;
      mode_active <= '0;
      mode_s2     <= '0;
    end else begin
      rgb_s1      <= vid.din;
      sync_s1     <= {vid.hsync, vid.vsync, vid.csync, vid.de};
      mode_active <= mode_nx;
      sync_s2     <= sync_s1;
      mode_s2     <= mode_active;
      sync_s3     <= sync_s2;
    end
  end

  // black level equals the mode's offset, so blanking just forces the offset out
  assign blank_s2 = (BLANK != 0) && !sync_s2[0];
  assign y_off    = (mode_s2 == 2'd2) ? Y_LIM : '0;
  assign c_off    = (mode_s2 == 2'd0) ? '0 : C_MID;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [29:0] k;
    assign k = coefs(mode_active, l);
    video_csc_lane #(.DW(DW)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .r       (rgb_s1[3*DW-1 -: DW]),
      .g       (rgb_s1[2*DW-1 -: DW]),
      .b       (rgb_s1[DW-1:0]),
      .kr      ($signed(k[29:20])),
      .kg      ($signed(k[19:10])),
      .kb      ($signed(k[9:0])),
      .off     ((l == 1) ? y_off : c_off),
      .blank   (blank_s2),
      .q       (dout_s3[l*DW +: DW])
    );
  end

  assign out_s3 = {dout_s3, sync_s3};

  if (EXTRA_DELAY > 0) begin : g_xdly
    logic [EXTRA_DELAY-1:0][OW-1:0] xpipe;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        xpipe <= '0;
      end else begin
        xpipe[0] <= out_s3;
        for (int i = 1; i < EXTRA_DELAY; i++) xpipe[i] <= xpipe[i-1];
      end
    end
    assign out_w = xpipe[EXTRA_DELAY-1];
  end else begin : g_nodly
    assign out_w = out_s3;
  end

  assign vid.dout        = out_w[OW-1:4];
  assign vid.hsync_o     = out_w[3];
  assign vid.vsync_o     = out_w[2];
  assign vid.csync_o     = out_w[1];
  assign vid.de_o        = out_w[0];
  assign vid.mode_active = mode_active;
endmodule

// File: doc/video_csc_out.md
Name: video_csc_out

Overview:
Parametrised colour-space converter and sync aligner for the analogue video output path. It takes packed RGB plus hsync/vsync/csync/de from the core. It emits RGB passthrough, full-range YPbPr (BT.601 or BT.709) or limited-range YCbCr (BT.601), with sync and DE delayed to match the video exactly. Mode changes are deferred to the next frame boundary so that no frame is output with mixed colour spaces.

Parameters:
DW, 8, bits per colour component in and out (legal 8..10)
EXTRA_DELAY, 0, additional register stages appended to both video and sync paths (legal 0..4)
BLANK, 1, 1 = force dout to the mode's black level while de_o is low; 0 = no blanking

Ports:
clk  in  1  video/pixel clock
reset_n  in  1  asynchronous active-low reset
mode_req  in  2  requested mode: 0 RGB, 1 YPbPr BT.601 full, 2 YCbCr BT.601 limited, 3 YPbPr BT.709 full
hsync  in  1  horizontal sync
vsync  in  1  vertical sync, active high
csync  in  1  composite sync
de  in  1  data enable
din  in  3*DW  {R,G,B}, R in the MSBs
dout  out  3*DW  {R,G,B} in mode 0; {Pr/Cr,Y,Pb/Cb} in modes 1-3
hsync_o  out  1  hsync delayed by LAT
vsync_o  out  1  vsync delayed by LAT
csync_o  out  1  csync delayed by LAT
de_o  out  1  de delayed by LAT
mode_active  out  2  mode currently being applied at pipeline input

Behaviour:
- Reset (async assert, sync release): dout, hsync_o, vsync_o, csync_o, de_o, mode_active and all pipeline and pending registers = 0.
- Latency LAT = 3 + EXTRA_DELAY cycles in every mode, including mode 0. There is one output per cycle and no stalls.
- Stage 1: input register and vsync edge detect. Stage 2: per-channel products and sums. Stage 3: rounding, offset, clamp and blanking. The EXTRA_DELAY stages follow stage 3.
- Coefficients are signed 8-bit fraction (scale 256):
  - mode 1: Y = 77R+150G+29B; Pb = -43R-85G+128B; Pr = 128R-107G-21B.
  - mode 3: Y = 54R+183G+19B; Pb = -29R-99G+128B; Pr = 128R-116G-12B.
  - mode 2: Y = 66R+129G+25B; Cb = -38R-74G+112B; Cr = 112R-94G-18B.
- Offsets (S = 2^(DW-8)):
  - Y: 0 in modes 1 and 3; 16*S in mode 2.
  - Chroma: 128*S in all YUV modes.
- Result = (sum + (offset<<8) + 128) arithmetic >>8. Sum width is DW+11 signed; no intermediate overflow is permitted.
- Clamp: result < 0 gives 0; result > 2^DW-1 gives 2^DW-1.
- Mode 0: din is delayed unchanged through LAT stages.
- Mode switch:
  - When mode_req != mode_active, the request is pending.
  - On a cycle where stage 1 detects a vsync rising edge (vsync=1, previous vsync=0), mode_active <= mode_req, and that pixel onward uses the new mode.
  - The first new-mode output therefore coincides with the vsync_o rising edge.
  - mode_req changes between edges: only the value present at the edge is taken.
  - vsync held high or low indefinitely: no switch occurs.
- Blanking (BLANK=1): when the delayed de is 0, dout = black for the mode of that pixel:
  - mode 0: all 0.
  - modes 1 and 3: Y=0, C=128*S.
  - mode 2: Y=16*S, C=128*S.
- Sync and de are never modified, only delayed.
- Reset mid-stream: outputs drop to 0 immediately. After release, the first real input appears at dout LAT cycles later, and mode_active restarts at 0.

Test Plan (DW=8, EXTRA_DELAY=0, BLANK=1 unless stated):
- Passthrough: mode_req=0, de=1, din=0x123456 → dout=0x123456 exactly 3 cycles later; hsync_o/vsync_o/de_o equal the inputs delayed 3 cycles.
- White/black, mode 1 (after a vsync edge): din=0xFFFFFF → 0x80FF80; din=0x000000 → 0x800080.
- Clamp/arith, mode 1: din=0xFF0000 → dout=0xFF4D55 (Pr=256 clamped to 255, Y=77, Pb=85).
- Limited range, mode 2: din=0xFFFFFF → 0x80EB80; din=0x000000 → 0x801080. With de=0 and din=0xFFFFFF → 0x801080.
- Deferred switch: in mode 0, raise mode_req to 1 mid-frame → mode_active stays 0 and dout stays RGB until the vsync rise. The first YPbPr output appears on the same cycle vsync_o rises. With EXTRA_DELAY=2, the same scenario holds with a 5-cycle latency.
- Reset: pulse reset_n low mid-line → all outputs 0 asynchronously and mode_active=0. After release, din=0xABCDEF in mode 0 → dout=0xABCDEF after 3 cycles.
